// File: rtl/uart_pkg.sv
// Shared UART types and default frame geometry.
// Imported by the receiver and its helpers.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
// Both flops are preset to RESET_VAL so an idle line reads idle out of reset.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampled 8N1 UART receiver with a one-byte valid/ready output register.
// Reports sticky framing errors and overruns when the consumer stalls.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_datastream,
    input  logic                 rx_data_ready,
    input  logic                 rx_framing_err_clr,
    output logic                 rx_data_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_overrun,
    output logic                 rx_framing_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic line;

    rx_state_t            state, state_n;
    logic [TW-1:0]        tick, tick_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic                 deliver;
    logic                 ferr_set;
    logic                 handshake;

    uart_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx_datastream),
        .q    (line)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick      <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_n;
            tick      <= tick_n;
            bit_cnt   <= bit_n;
            shift_reg <= shift_n;
        end
    end

    always_comb begin
        state_n  = state;
        tick_n   = tick + 1'b1;
        bit_n    = bit_cnt;
        shift_n  = shift_reg;
        deliver  = 1'b0;
        ferr_set = 1'b0;
        unique case (state)
            IDLE: begin
                tick_n = '0;
                if (!line) state_n = START;
            end
            START: begin
                // Mid start bit: a high line here was only a glitch.
                if (tick == TICK_HALF) begin
                    tick_n = '0;
                    if (line) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        bit_n   = '0;
                    end
                end
            end
            DATA: begin
                if (tick == TICK_LAST) begin
                    tick_n  = '0;
                    shift_n = {line, shift_reg[DATA_BITS-1:1]};
                    if (bit_cnt == BIT_LAST) state_n = STOP;
                    else bit_n = bit_cnt + 1'b1;
                end
            end
            STOP: begin
                if (tick == TICK_LAST) begin
                    tick_n = '0;
                    if (line) begin
                        deliver = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = BREAK_WAIT;
                    end
                end
            end
            BREAK_WAIT: begin
                tick_n = '0;
                if (line) state_n = IDLE;
            end
            default: begin
                tick_n  = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign handshake = rx_data_valid && rx_data_ready;

    // A delivery in the same cycle as a handshake refills the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_valid <= 1'b0;
            rx_data       <= '0;
            rx_overrun    <= 1'b0;
        end else begin
            if (deliver && (!rx_data_valid || rx_data_ready)) begin
                rx_data       <= shift_reg;
                rx_data_valid <= 1'b1;
            end else if (handshake) begin
                rx_data_valid <= 1'b0;
            end
            if (deliver && rx_data_valid && !rx_data_ready) begin
                rx_overrun <= 1'b1;
            end else if (handshake) begin
                rx_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_framing_err <= 1'b0;
        end else if (ferr_set) begin
            rx_framing_err <= 1'b1;
        end else if (rx_framing_err_clr) begin
            rx_framing_err <= 1'b0;
        end
    end

endmodule
